adc_config_arbiter: RTL

- Shares one ADC three-wire config port between NUM_REQ independent requesters, e.g. OPB software writes, the auto-calibration engine and the DDR/mode bring-up logic.
- The config port is a start/busy pair plus 3-bit address and 16-bit data.
- Picks one pending write with round-robin priority, issues a single-cycle start, and tracks the port's busy flag through completion.
- Reports per-requester completion, and a timeout error if busy never rises.

---
 rtl/adc_config_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/adc_config_arbiter.sv
// Round-robin arbiter sharing one ADC start/busy config port between NUM_REQ requesters.
// Optional per-requester grant lock for atomic multi-word sequences: define ADC_CFG_ARB_LOCK_EN.
module adc_config_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [3*NUM_REQ-1:0]  req_addr_i,
  input  logic [16*NUM_REQ-1:0] req_data_i,
`ifdef ADC_CFG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock_i,
`endif
  output logic [NUM_REQ-1:0]    req_ack_o,
  output logic [NUM_REQ-1:0]    req_done_o,
  output logic [NUM_REQ-1:0]    req_err_o,
  output logic                  cfg_start_o,
  output logic [2:0]            cfg_addr_o,
  output logic [15:0]           cfg_data_o,
  input  logic                  cfg_busy_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  idle_o
);

  localparam int unsigned PtrW        = $clog2(NUM_REQ);
  localparam logic [7:0]  TimeoutLast = 8'(BUSY_TIMEOUT - 1);
  localparam logic [PtrW:0] NumReqW   = (PtrW+1)'(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e              state_q;
  logic [PtrW-1:0]     ptr_q;
  logic [PtrW-1:0]     owner_q;
  logic [7:0]          cnt_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [NUM_REQ-1:0]  err_q;
  logic                start_q;
  logic [2:0]          addr_q;
  logic [15:0]         data_q;

  logic                sel_found;
  logic [PtrW-1:0]     sel_idx;
  logic [NUM_REQ-1:0]  sel_onehot;
  logic [2:0]          sel_addr;
  logic [15:0]         sel_data;
  logic [PtrW:0]       cand;
  logic [PtrW-1:0]     ptr_next;
  logic [7:0]          cnt_inc;
  logic                finish;
  logic                finish_err;
  logic                lock_hold;
  logic                lock_release;

`ifdef ADC_CFG_ARB_LOCK_EN
  logic       locked_q;
  logic [7:0] lock_cnt_q;

  assign lock_hold    = req_lock_i[owner_q];
  // Release when the owner drops lock, or after 256 idle cycles with no write from it.
  assign lock_release = locked_q && (state_q == StIdle) &&
                        (!req_lock_i[owner_q] ||
                         (!req_valid_i[owner_q] && (lock_cnt_q == 8'hff)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else if (finish) begin
      locked_q   <= lock_hold;
      lock_cnt_q <= '0;
    end else if (lock_release) begin
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else if (locked_q && (state_q == StIdle)) begin
      lock_cnt_q <= req_valid_i[owner_q] ? 8'd0 : lock_cnt_q + 8'd1;
    end
  end
`else
  assign lock_hold    = 1'b0;
  assign lock_release = 1'b0;
`endif

  // First pending requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!sel_found && req_valid_i[cand[PtrW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PtrW-1:0];
      end
    end
`ifdef ADC_CFG_ARB_LOCK_EN
    if (locked_q) begin
      sel_found = req_valid_i[owner_q] && !lock_release;
      sel_idx   = owner_q;
    end
`endif
  end

  always_comb begin
    sel_onehot = '0;
    sel_addr   = '0;
    sel_data   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PtrW'(i) == sel_idx) begin
        sel_onehot[i] = 1'b1;
        sel_addr      = req_addr_i[3*i +: 3];
        sel_data      = req_data_i[16*i +: 16];
      end
    end
  end

  always_comb begin
    ptr_next   = (owner_q == PtrW'(NUM_REQ - 1)) ? '0 : owner_q + PtrW'(1);
    cnt_inc    = cnt_q + 8'd1;
    finish_err = (state_q == StWaitBusy) && !cfg_busy_i && (cnt_inc == TimeoutLast);
    finish     = finish_err || ((state_q == StWaitDone) && !cfg_busy_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (lock_release) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
          end else if (sel_found) begin
            owner_q <= sel_idx;
            grant_q <= sel_onehot;
            addr_q  <= sel_addr;
            data_q  <= sel_data;
            start_q <= 1'b1;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (cfg_busy_i) begin
            state_q <= StWaitDone;
          end else begin
            cnt_q <= cnt_inc;
            if (finish_err) begin
              state_q <= StIdle;
            end
          end
        end
        StWaitDone: begin
          if (!cfg_busy_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (finish) begin
        done_q <= grant_q;
        err_q  <= finish_err ? grant_q : '0;
        if (!lock_hold) begin
          grant_q <= '0;
          ptr_q   <= ptr_next;
        end
      end
    end
  end

  assign req_ack_o   = (rst_n && (state_q == StIdle) && sel_found) ? sel_onehot : '0;
  assign req_done_o  = done_q;
  assign req_err_o   = err_q;
  assign cfg_start_o = start_q;
  assign cfg_addr_o  = addr_q;
  assign cfg_data_o  = data_q;
  assign grant_o     = grant_q;
  assign idle_o      = (state_q == StIdle) && (grant_q == '0);

endmodule
